// File: rtl/jt12_pg_seq_pkg.sv
// jt12_pg_seq_pkg
// Shared constants for the phase-generator slot sequencer: slot count,
// pipeline stage offsets, register write-select codes, the operator group
// order, and a wrap-around slot subtraction helper.
package jt12_pg_seq_pkg;

  localparam int SLOTS = 24;

  // How many slots each later pipeline stage trails stage I
  localparam logic [4:0] OFS_II  = 5'd1;
  localparam logic [4:0] OFS_III = 5'd2;
  localparam logic [4:0] OFS_V   = 5'd4;

  typedef enum logic [2:0] {
    SEL_FHI    = 3'd0,
    SEL_FLO_CH = 3'd1,
    SEL_FLO_SP = 3'd2,
    SEL_MULDT  = 3'd3,
    SEL_KON    = 3'd4,
    SEL_MODE   = 3'd5
  } wr_sel_e;

  // Operator groups in slot order: S1, S3, S2, S4
  localparam logic [1:0] GRP_S1 = 2'd0;
  localparam logic [1:0] GRP_S3 = 2'd1;
  localparam logic [1:0] GRP_S2 = 2'd2;
  localparam logic [1:0] GRP_S4 = 2'd3;

  // (s - ofs) mod 24, for s in 0..23 and ofs <= 4
  function automatic logic [4:0] slot_sub(input logic [4:0] s, input logic [4:0] ofs);
    if (s >= ofs) slot_sub = s - ofs;
    else          slot_sub = s + 5'(SLOTS) - ofs;
  endfunction

endpackage

// File: rtl/jt12_pg_seq_slot.sv
// jt12_pg_seq_slot
// Channel/group slot counter. The counter holds the slot currently in
// stage I; the outputs describe the slot that the next clk_en edge will
// move to, so the top can fetch that slot's parameters on the same edge.
// Ports:
//   i_clk, i_rst_n, i_clk_en  clock, async active-low reset, advance strobe
//   o_ch_I, o_grp_I           channel / operator group of the next stage-I slot
//   o_slot_I                  next stage-I slot number
//   o_slot_II/_III/_V         slots trailing it by 1, 2 and 4 (mod 24)
module jt12_pg_seq_slot
  import jt12_pg_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clk_en,
  output logic [2:0] o_ch_I,
  output logic [1:0] o_grp_I,
  output logic [4:0] o_slot_I,
  output logic [4:0] o_slot_II,
  output logic [4:0] o_slot_III,
  output logic [4:0] o_slot_V
);

  logic [2:0] r_ch;
  logic [1:0] r_grp;
  logic [2:0] w_ch_nx;
  logic [1:0] w_grp_nx;
  logic [4:0] w_slot_nx;

  // Reset parks the counter on slot 23 so the first advance lands on slot 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ch  <= 3'd5;
      r_grp <= 2'd3;
    end else if (i_clk_en) begin
      r_ch  <= w_ch_nx;
      r_grp <= w_grp_nx;
    end
  end

  // slot = grp*6 + ch, built from shifts; the 2-bit group wraps by itself
  always_comb begin
    w_ch_nx   = (r_ch == 3'd5) ? 3'd0 : r_ch + 3'd1;
    w_grp_nx  = (r_ch == 3'd5) ? r_grp + 2'd1 : r_grp;
    w_slot_nx = {1'b0, w_grp_nx, 2'b00} + {2'b00, w_grp_nx, 1'b0} + {2'b00, w_ch_nx};
  end

  assign o_ch_I     = w_ch_nx;
  assign o_grp_I    = w_grp_nx;
  assign o_slot_I   = w_slot_nx;
  assign o_slot_II  = slot_sub(w_slot_nx, OFS_II);
  assign o_slot_III = slot_sub(w_slot_nx, OFS_III);
  assign o_slot_V   = slot_sub(w_slot_nx, OFS_V);

endmodule

// File: rtl/jt12_pg_seq.sv
// jt12_pg_seq
// Slot sequencer and register front-end for the jt12 phase generator.
// Holds per-channel frequency, ch3 special frequencies, per-slot mul/dt1
// and key-on state, and presents each to the stage that consumes it.
// Ports:
//   clk, rst (async active-low), clk_en (slot advance)
//   wr_en, wr_sel, wr_idx, wr_data   register write port, ignores clk_en
//   fnum_I, block_I   frequency of stage-I slot
//   dt1_II            detune of stage-II slot
//   pg_rst_III        phase reset pulse of stage-III slot
//   mul_V             multiplier of stage-V slot
//   zero, slot_I      stage-I slot is 0 / stage-I slot number
module jt12_pg_seq
  import jt12_pg_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [4:0]  wr_idx,
  input  logic [7:0]  wr_data,
  output logic [10:0] fnum_I,
  output logic [2:0]  block_I,
  output logic [2:0]  dt1_II,
  output logic        pg_rst_III,
  output logic [3:0]  mul_V,
  output logic        zero,
  output logic [4:0]  slot_I
);

  logic [2:0]  w_ch_I;
  logic [1:0]  w_grp_I;
  logic [4:0]  w_slot_I;
  logic [4:0]  w_slot_II;
  logic [4:0]  w_slot_III;
  logic [4:0]  w_slot_V;

  logic [5:0]  r_latch;
  logic        r_mode;
  logic [13:0] r_chfreq [0:5];
  logic [13:0] r_spfreq [0:2];
  logic [3:0]  r_mul [0:23];
  logic [2:0]  r_dt1 [0:23];
  logic [23:0] r_kon;
  logic [23:0] r_kon_prev;

  logic        w_ch_ok;
  logic        w_sp_ok;
  logic        w_slot_ok;
  logic [23:0] w_kon_nx;
  logic [13:0] w_freq_I;

  jt12_pg_seq_slot u_slot (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_clk_en   (clk_en),
    .o_ch_I     (w_ch_I),
    .o_grp_I    (w_grp_I),
    .o_slot_I   (w_slot_I),
    .o_slot_II  (w_slot_II),
    .o_slot_III (w_slot_III),
    .o_slot_V   (w_slot_V)
  );

  assign w_ch_ok   = (wr_idx < 5'd6);
  assign w_sp_ok   = (wr_idx < 5'd3);
  assign w_slot_ok = (wr_idx < 5'd24);

  // Key mask bits are S4,S3,S2,S1 but slot groups run S1,S3,S2,S4,
  // so S2 and S3 swap places when spread over the channel's slots
  always_comb begin
    w_kon_nx = r_kon;
    if (w_ch_ok) begin
      w_kon_nx[wr_idx]          = wr_data[0];
      w_kon_nx[wr_idx + 5'd6]   = wr_data[2];
      w_kon_nx[wr_idx + 5'd12]  = wr_data[1];
      w_kon_nx[wr_idx + 5'd18]  = wr_data[3];
    end
  end

  // Register file; out-of-range targets are simply not written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_latch <= '0;
      r_mode  <= 1'b0;
      r_kon   <= '0;
      for (int i = 0; i < 6; i++) r_chfreq[i] <= '0;
      for (int i = 0; i < 3; i++) r_spfreq[i] <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_mul[i] <= '0;
        r_dt1[i] <= '0;
      end
    end else if (wr_en) begin
      case (wr_sel)
        SEL_FHI:    r_latch <= wr_data[5:0];
        SEL_FLO_CH: if (w_ch_ok) r_chfreq[wr_idx[2:0]] <= {r_latch, wr_data};
        SEL_FLO_SP: if (w_sp_ok) r_spfreq[wr_idx[1:0]] <= {r_latch, wr_data};
        SEL_MULDT: begin
          if (w_slot_ok) begin
            r_mul[wr_idx] <= wr_data[3:0];
            r_dt1[wr_idx] <= wr_data[6:4];
          end
        end
        SEL_KON:    r_kon  <= w_kon_nx;
        SEL_MODE:   r_mode <= wr_data[0];
        default:    ;
      endcase
    end
  end

  // Channel 2 operators S1/S3/S2 follow the special registers in ch3 mode
  always_comb begin
    w_freq_I = r_chfreq[w_ch_I];
    if (r_mode && (w_ch_I == 3'd2) && (w_grp_I != GRP_S4)) begin
      case (w_grp_I)
        GRP_S1:  w_freq_I = r_spfreq[0];
        GRP_S3:  w_freq_I = r_spfreq[1];
        default: w_freq_I = r_spfreq[2];
      endcase
    end
  end

  // Stage outputs and key-on edge memory; kon_prev samples the old kon
  // so a key-on written on the same edge pulses on the following frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fnum_I     <= '0;
      block_I    <= '0;
      dt1_II     <= '0;
      pg_rst_III <= 1'b0;
      mul_V      <= '0;
      zero       <= 1'b0;
      slot_I     <= '0;
      r_kon_prev <= '0;
    end else if (clk_en) begin
      slot_I                 <= w_slot_I;
      zero                   <= (w_slot_I == 5'd0);
      fnum_I                 <= w_freq_I[10:0];
      block_I                <= w_freq_I[13:11];
      dt1_II                 <= r_dt1[w_slot_II];
      pg_rst_III             <= r_kon[w_slot_III] & ~r_kon_prev[w_slot_III];
      r_kon_prev[w_slot_III] <= r_kon[w_slot_III];
      mul_V                  <= r_mul[w_slot_V];
    end
  end

endmodule

// File: tb/tb_jt12_pg_seq.sv
// tb_jt12_pg_seq
// Directed bench for the phase-generator slot sequencer. Inputs change on
// the falling edge; outputs are sampled on the falling edge after the
// rising edge that consumed them. The bench tracks the stage-I slot itself.
module tb_jt12_pg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_sel = '0;
  logic [4:0]  wr_idx = '0;
  logic [7:0]  wr_data = '0;
  logic [10:0] fnum_I;
  logic [2:0]  block_I;
  logic [2:0]  dt1_II;
  logic        pg_rst_III;
  logic [3:0]  mul_V;
  logic        zero;
  logic [4:0]  slot_I;

  int nAssert = 0;
  int nFail   = 0;
  int curSlot = 23;

  jt12_pg_seq dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .fnum_I     (fnum_I),
    .block_I    (block_I),
    .dt1_II     (dt1_II),
    .pg_rst_III (pg_rst_III),
    .mul_V      (mul_V),
    .zero       (zero),
    .slot_I     (slot_I)
  );

  always #5 clk = ~clk;

  // One comparison: counted, and reported with tag, observed and expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of inputs starting at a falling edge, return at the next one
  task automatic applyStimulus(input logic en, input logic we, input logic [2:0] sel,
                               input logic [4:0] idx, input logic [7:0] data);
    clk_en  = en;
    wr_en   = we;
    wr_sel  = sel;
    wr_idx  = idx;
    wr_data = data;
    @(negedge clk);
    clk_en = 1'b0;
    wr_en  = 1'b0;
    if (en) curSlot = (curSlot == 23) ? 0 : curSlot + 1;
  endtask

  task automatic writeReg(input logic [2:0] sel, input logic [4:0] idx, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, sel, idx, data);
  endtask

  // Advance at least once, until the stage-I slot equals target
  task automatic runToSlot(input int target);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 8'd0);
      n++;
    end while (curSlot != target && n < 24);
    checkOutput($sformatf("slot_I@%0d", target), 32'(slot_I), 32'(target));
  endtask

  // Frequency programmed on each channel by the time of the frame check
  function automatic int expFnum(input int s);
    int ch;
    ch = s % 6;
    if (ch == 2) return 'h567;
    if (ch == 3) return 'h29A;
    return 0;
  endfunction

  function automatic int expBlock(input int s);
    int ch;
    ch = s % 6;
    if (ch == 2) return 2;
    if (ch == 3) return 4;
    return 0;
  endfunction

  initial begin
    int p1;
    int p4;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst fnum_I", 32'(fnum_I), 0);
    checkOutput("rst block_I", 32'(block_I), 0);
    checkOutput("rst dt1_II", 32'(dt1_II), 0);
    checkOutput("rst pg_rst_III", 32'(pg_rst_III), 0);
    checkOutput("rst mul_V", 32'(mul_V), 0);
    checkOutput("rst zero", 32'(zero), 0);
    checkOutput("rst slot_I", 32'(slot_I), 0);
    rst = 1'b1;
    $display("[TB] reset released");

    // Slot walk over one frame plus the wrap
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 8'd0);
      checkOutput($sformatf("walk slot_I %0d", i), 32'(slot_I), 32'(i));
      checkOutput($sformatf("walk zero %0d", i), 32'(zero), (i == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 8'd0);
    checkOutput("wrap slot_I", 32'(slot_I), 0);
    checkOutput("wrap zero", 32'(zero), 1);

    // Channel frequency through the shared latch
    writeReg(3'd0, 5'd0, 8'h22);
    writeReg(3'd1, 5'd3, 8'h9A);
    runToSlot(3);
    checkOutput("ch3 fnum s3", 32'(fnum_I), 'h29A);
    checkOutput("ch3 block s3", 32'(block_I), 4);
    runToSlot(4);
    checkOutput("ch4 fnum s4", 32'(fnum_I), 0);
    runToSlot(9);
    checkOutput("ch3 fnum s9", 32'(fnum_I), 'h29A);
    checkOutput("ch3 block s9", 32'(block_I), 4);

    // Ch3 special mode
    writeReg(3'd0, 5'd0, 8'h15);
    writeReg(3'd1, 5'd2, 8'h67);
    writeReg(3'd0, 5'd0, 8'h01);
    writeReg(3'd2, 5'd0, 8'h00);
    writeReg(3'd0, 5'd0, 8'h02);
    writeReg(3'd2, 5'd1, 8'h00);
    writeReg(3'd0, 5'd0, 8'h03);
    writeReg(3'd2, 5'd2, 8'h00);
    runToSlot(14);
    checkOutput("mode0 fnum s14", 32'(fnum_I), 'h567);
    checkOutput("mode0 block s14", 32'(block_I), 2);
    writeReg(3'd5, 5'd0, 8'h01);
    runToSlot(20);
    checkOutput("mode1 fnum s20", 32'(fnum_I), 'h567);
    checkOutput("mode1 block s20", 32'(block_I), 2);
    runToSlot(2);
    checkOutput("mode1 fnum s2", 32'(fnum_I), 'h100);
    checkOutput("mode1 block s2", 32'(block_I), 0);
    runToSlot(8);
    checkOutput("mode1 fnum s8", 32'(fnum_I), 'h200);
    runToSlot(14);
    checkOutput("mode1 fnum s14", 32'(fnum_I), 'h300);
    writeReg(3'd5, 5'd0, 8'h00);
    runToSlot(20);
    checkOutput("mode0b fnum s20", 32'(fnum_I), 'h567);
    runToSlot(2);
    checkOutput("mode0b fnum s2", 32'(fnum_I), 'h567);
    runToSlot(8);
    checkOutput("mode0b fnum s8", 32'(fnum_I), 'h567);

    // mul/dt1 stage alignment, including the wrap from slot 23
    writeReg(3'd3, 5'd7, 8'h5B);
    runToSlot(7);
    checkOutput("dt1 before s7", 32'(dt1_II), 0);
    applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 8'd0);
    checkOutput("dt1_II slot7", 32'(dt1_II), 5);
    checkOutput("mul_V slot4", 32'(mul_V), 0);
    repeat (3) applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 8'd0);
    checkOutput("mul_V slot7", 32'(mul_V), 'hB);
    checkOutput("dt1_II slot10", 32'(dt1_II), 0);
    writeReg(3'd3, 5'd23, 8'h3C);
    runToSlot(0);
    checkOutput("dt1_II slot23 wrap", 32'(dt1_II), 3);
    checkOutput("zero at wrap", 32'(zero), 1);
    runToSlot(3);
    checkOutput("mul_V slot23 wrap", 32'(mul_V), 'hC);

    // Key-on edge pulses for channel 1
    runToSlot(2);
    writeReg(3'd4, 5'd1, 8'h0F);
    runToSlot(3);
    checkOutput("kon pulse s1", 32'(pg_rst_III), 1);
    runToSlot(4);
    checkOutput("kon no pulse s2", 32'(pg_rst_III), 0);
    runToSlot(9);
    checkOutput("kon pulse s7", 32'(pg_rst_III), 1);
    runToSlot(15);
    checkOutput("kon pulse s13", 32'(pg_rst_III), 1);
    runToSlot(21);
    checkOutput("kon pulse s19", 32'(pg_rst_III), 1);
    runToSlot(3);
    checkOutput("kon held s1", 32'(pg_rst_III), 0);
    runToSlot(9);
    checkOutput("kon held s7", 32'(pg_rst_III), 0);
    writeReg(3'd4, 5'd1, 8'h00);
    runToSlot(9);
    checkOutput("koff no pulse s7", 32'(pg_rst_III), 0);
    runToSlot(2);
    writeReg(3'd4, 5'd1, 8'h0F);
    runToSlot(3);
    checkOutput("rekon pulse s1", 32'(pg_rst_III), 1);

    // Mask bit S3 maps to the second group (slot 7 of channel 1)
    writeReg(3'd4, 5'd1, 8'h00);
    runToSlot(2);
    writeReg(3'd4, 5'd1, 8'h04);
    runToSlot(3);
    checkOutput("mask S3 s1", 32'(pg_rst_III), 0);
    runToSlot(9);
    checkOutput("mask S3 s7", 32'(pg_rst_III), 1);
    runToSlot(15);
    checkOutput("mask S3 s13", 32'(pg_rst_III), 0);

    // Key-on written on the edge where slot 0 passes stage III
    runToSlot(1);
    applyStimulus(1'b1, 1'b1, 3'd4, 5'd0, 8'h01);
    checkOutput("kon coincident", 32'(pg_rst_III), 0);
    runToSlot(2);
    checkOutput("kon next frame", 32'(pg_rst_III), 1);

    // Out-of-range writes leave every output as it was
    writeReg(3'd1, 5'd6, 8'hFF);
    writeReg(3'd2, 5'd3, 8'hFF);
    writeReg(3'd7, 5'd0, 8'hFF);
    writeReg(3'd3, 5'd24, 8'hFF);
    writeReg(3'd4, 5'd6, 8'h0F);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0, 8'd0);
      p1 = (curSlot + 23) % 24;
      p4 = (curSlot + 20) % 24;
      checkOutput($sformatf("frame fnum s%0d", curSlot), 32'(fnum_I), 32'(expFnum(curSlot)));
      checkOutput($sformatf("frame block s%0d", curSlot), 32'(block_I), 32'(expBlock(curSlot)));
      checkOutput($sformatf("frame pg s%0d", curSlot), 32'(pg_rst_III), 0);
      checkOutput($sformatf("frame dt1 s%0d", curSlot), 32'(dt1_II),
                  (p1 == 7) ? 32'd5 : (p1 == 23) ? 32'd3 : 32'd0);
      checkOutput($sformatf("frame mul s%0d", curSlot), 32'(mul_V),
                  (p4 == 7) ? 32'hB : (p4 == 23) ? 32'hC : 32'd0);
    end

    // Mid-frame reset
    runToSlot(8);
    checkOutput("pre-rst fnum", 32'(fnum_I), 'h567);
    checkOutput("pre-rst dt1", 32'(dt1_II), 5);
    rst = 1'b0;
    #1;
    checkOutput("midrst fnum_I", 32'(fnum_I), 0);
    checkOutput("midrst block_I", 32'(block_I), 0);
    checkOutput("midrst dt1_II", 32'(dt1_II), 0);
    checkOutput("midrst slot_I", 32'(slot_I), 0);
    checkOutput("midrst zero", 32'(zero), 0);
    @(negedge clk);
    rst = 1'b1;
    curSlot = 23;
    runToSlot(0);
    checkOutput("restart zero", 32'(zero), 1);
    runToSlot(3);
    checkOutput("restart fnum cleared", 32'(fnum_I), 0);
    runToSlot(8);
    checkOutput("restart dt1 cleared", 32'(dt1_II), 0);
    checkOutput("restart pg cleared", 32'(pg_rst_III), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
